bus6502_master: RTL and testbench

Bus initiator for the 6502-style peripheral interface: turns single read/write requests from internal logic into complete bus cycles on cs/rs/wren/data. It also generates the 1 MHz bus clock, clk_ext1, from the 50 MHz system clock. It sits upstream of the peripheral interface block and drives the same pins that block samples, as seen from the CPU side.

---
 rtl/bus6502_master_pkg.sv | 16 +
 rtl/bus6502_master_if.sv | 34 +++
 rtl/bus6502_master_phi2_gen.sv | 39 +++
 rtl/bus6502_master.sv | 128 ++++++++++++
 tb/tb_bus6502_master.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus6502_master_pkg.sv
// Shared types and constants for the 6502-style bus initiator.
// Holds the master FSM state encoding and default sizing.
package interface_6502_pkg;

   localparam int DIV_1MHZ = 25;
   localparam int RS_W     = 4;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      SETUP,
      ACTIVE,
      HOLD
   } state_e;

endpackage

// File: rtl/bus6502_master_if.sv
// Request/response handshake plus 6502 peripheral bus pins.
// master = bus initiator side, slave = requester/peripheral side.
interface bus6502_if #(
   parameter int RS_W = interface_6502_pkg::RS_W
);
   logic            req_valid;
   logic            req_ready;
   logic            req_write;
   logic [RS_W-1:0] req_addr;
   logic [7:0]      req_wdata;
   logic            rsp_valid;
   logic [7:0]      rsp_rdata;
   logic            busy;
   logic            clk_ext1;
   logic            cs;
   logic [RS_W-1:0] rs;
   logic            wren;
   logic [7:0]      data_out;
   logic            data_oe;
   logic [7:0]      data_in;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, data_in,
      output req_ready, rsp_valid, rsp_rdata, busy,
      output clk_ext1, cs, rs, wren, data_out, data_oe
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, data_in,
      input  req_ready, rsp_valid, rsp_rdata, busy,
      input  clk_ext1, cs, rs, wren, data_out, data_oe
   );

endinterface

// File: rtl/bus6502_master_phi2_gen.sv
// Free-running phi2 generator: divides the system clock by 2*DIV.
// rise/fall flag the system edge on which clk_ext1 toggles.
module phi2_gen #(
   parameter int DIV = 25
) (
   input  logic clk_int50,
   input  logic rst,
   output logic clk_ext1,
   output logic rise,
   output logic fall
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          clk_q, clk_d;
   logic          wrap;

   always_comb begin
      wrap  = (cnt_q == LAST);
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
      clk_d = clk_q ^ wrap;
   end

   always_ff @(posedge clk_int50 or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         clk_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         clk_q <= clk_d;
      end
   end

   assign clk_ext1 = clk_q;
   assign rise     = wrap & ~clk_q;
   assign fall     = wrap & clk_q;

endmodule

// File: rtl/bus6502_master.sv
// 6502-style bus initiator: one request becomes one cs/rs/wren cycle
// aligned to the generated phi2 clock.
module bus6502_master
   import interface_6502_pkg::*;
#(
   parameter int DIV  = DIV_1MHZ,
   parameter int RS_W = interface_6502_pkg::RS_W
) (
   input  logic      clk_int50,
   input  logic      rst,
   bus6502_if.master bus
);
   state_e state_q, state_d;

   logic            rise, fall, accept;
   logic            wr_q, wr_d;
   logic [RS_W-1:0] addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic            cs_q, cs_d;
   logic            wren_q, wren_d;
   logic [RS_W-1:0] rs_q, rs_d;
   logic [7:0]      dout_q, dout_d;
   logic            doe_q, doe_d;
   logic            rspv_q, rspv_d;
   logic [7:0]      rdata_q, rdata_d;

   phi2_gen #(.DIV(DIV)) u_phi2 (
      .clk_int50 (clk_int50),
      .rst       (rst),
      .clk_ext1  (bus.clk_ext1),
      .rise      (rise),
      .fall      (fall)
   );

   assign accept = bus.req_valid && (state_q == IDLE);

   always_ff @(posedge clk_int50 or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = WAIT;
         WAIT:    if (fall)   state_d = SETUP;
         SETUP:   if (rise)   state_d = ACTIVE;
         ACTIVE:  if (fall)   state_d = HOLD;
         HOLD:                state_d = IDLE;
         default:             state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cs_d    = cs_q;
      wren_d  = wren_q;
      rs_d    = rs_q;
      dout_d  = dout_q;
      doe_d   = doe_q;
      rspv_d  = 1'b0;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: if (accept) begin
            wr_d    = bus.req_write;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
         end
         WAIT: if (fall) begin
            cs_d   = 1'b0;
            rs_d   = addr_q;
            wren_d = ~wr_q;
            dout_d = wdata_q;
            doe_d  = wr_q;
         end
         ACTIVE: if (fall) begin
            cs_d = 1'b1;
            if (!wr_q) rdata_d = bus.data_in;
         end
         // cs is already high; release wren/data one cycle later
         HOLD: begin
            wren_d = 1'b1;
            doe_d  = 1'b0;
            rspv_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_int50 or posedge rst) begin
      if (rst) begin
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cs_q    <= 1'b1;
         wren_q  <= 1'b1;
         rs_q    <= '0;
         dout_q  <= '0;
         doe_q   <= 1'b0;
         rspv_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cs_q    <= cs_d;
         wren_q  <= wren_d;
         rs_q    <= rs_d;
         dout_q  <= dout_d;
         doe_q   <= doe_d;
         rspv_q  <= rspv_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.cs        = cs_q;
   assign bus.wren      = wren_q;
   assign bus.rs        = rs_q;
   assign bus.data_out  = dout_q;
   assign bus.data_oe   = doe_q;
   assign bus.rsp_valid = rspv_q;
   assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_bus6502_master.sv
// Directed bench for bus6502_master with a response scoreboard
// and a negedge bus monitor.
module tb_bus6502_master;
   localparam int DIV  = 4;
   localparam int LMIN = 2*DIV + 2;
   localparam int LMAX = 4*DIV + 2;

   typedef struct {
      logic       wr;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      int         acc;
   } txn_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total = 0;
   int   cyc = 0;
   int   rsp_count = 0;
   txn_t sb[$];
   logic [7:0] last_rd = 8'h00;

   bus6502_if #(.RS_W(4)) bif ();

   bus6502_master #(.DIV(DIV), .RS_W(4)) dut (
      .clk_int50 (clk),
      .rst       (rst),
      .bus       (bif.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [13:0] bus_exp(input txn_t t);
      return {t.addr, ~t.wr, t.wr, t.wdata};
   endfunction

   function automatic logic [13:0] bus_obs();
      return {bif.rs, bif.wren, bif.data_oe, bif.data_out};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [3:0] a,
                        input logic [7:0] d);
      bif.req_write = wr;
      bif.req_addr  = a;
      bif.req_wdata = d;
      bif.req_valid = 1'b1;
      tick();
      bif.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target);
      int n = 0;
      while (rsp_count < target && n < 60) begin
         tick();
         n++;
      end
      chk("rsp_timeout", 32'(rsp_count >= target), 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bif.busy !== 1'b0 && n < 60) begin
         tick();
         n++;
      end
      chk("idle_timeout", bif.busy, 0);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // bus monitor and scoreboard
   initial begin
      txn_t t;
      int   lat;
      logic prev_cs = 1'b1;
      logic prev_clk = 1'b0;
      logic prev_rsp = 1'b0;
      int   low_len = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
            last_rd  = 8'h00;
            prev_cs  = 1'b1;
            prev_rsp = 1'b0;
            low_len  = 0;
         end else begin
            if (bif.rsp_valid) begin
               chk("rsp_pulse_width", prev_rsp, 0);
               if (sb.size() == 0) chk("rsp_spurious", 1, 0);
               else begin
                  t = sb.pop_front();
                  chk("rsp_rdata", bif.rsp_rdata, t.rdata);
                  lat = cyc - t.acc;
                  chk("latency_range", 32'(lat >= LMIN && lat <= LMAX), 1);
               end
               rsp_count++;
            end
            if (!bif.cs) begin
               if (prev_cs) begin
                  chk("cs_fall_on_phi2_fall", {prev_clk, bif.clk_ext1}, 2'b10);
                  low_len = 1;
               end else low_len++;
               if (sb.size() == 0) chk("cs_low_no_txn", 1, 0);
               else chk("bus_during_cs", bus_obs(), bus_exp(sb[0]));
            end else if (!prev_cs) begin
               chk("cs_low_len", low_len, 2*DIV);
               if (sb.size() == 0) chk("hold_no_txn", 1, 0);
               else chk("bus_hold_after_cs", bus_obs(), bus_exp(sb[0]));
            end
            if (bif.req_valid && bif.req_ready) begin
               chk("no_overlap", sb.size(), 0);
               t.wr    = bif.req_write;
               t.addr  = bif.req_addr;
               t.wdata = bif.req_wdata;
               t.acc   = cyc + 1;
               if (!bif.req_write) last_rd = bif.data_in;
               t.rdata = last_rd;
               sb.push_back(t);
            end
         end
         prev_cs  = bif.cs;
         prev_clk = bif.clk_ext1;
         prev_rsp = bif.rsp_valid;
      end
   end

   initial begin
      int base;
      int n;
      bif.req_valid = 1'b0;
      bif.req_write = 1'b0;
      bif.req_addr  = 4'h0;
      bif.req_wdata = 8'h00;
      bif.data_in   = 8'h00;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cs", bif.cs, 1);
      chk("rst_wren", bif.wren, 1);
      chk("rst_rs", bif.rs, 0);
      chk("rst_data_out", bif.data_out, 0);
      chk("rst_data_oe", bif.data_oe, 0);
      chk("rst_rsp_valid", bif.rsp_valid, 0);
      chk("rst_rsp_rdata", bif.rsp_rdata, 0);
      chk("rst_busy", bif.busy, 0);
      chk("rst_req_ready", bif.req_ready, 1);
      chk("rst_clk_ext1", bif.clk_ext1, 0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         if (i > 0) tick();
         chk("phi2_pattern", bif.clk_ext1, 32'((i / DIV) % 2));
      end
      chk("idle_busy", bif.busy, 0);
      chk("idle_req_ready", bif.req_ready, 1);

      // single write
      wait_idle();
      base = rsp_count;
      issue(1'b1, 4'h3, 8'hA5);
      chk("write_busy", bif.busy, 1);
      wait_rsp(base + 1);
      chk("write_keeps_rdata", bif.rsp_rdata, 8'h00);
      repeat (20) tick();
      chk("write_one_rsp", rsp_count, base + 1);

      // single read
      wait_idle();
      bif.data_in = 8'h5A;
      base = rsp_count;
      issue(1'b0, 4'hC, 8'h00);
      wait_rsp(base + 1);
      chk("read_rdata", bif.rsp_rdata, 8'h5A);
      bif.data_in = 8'h00;

      // back-to-back with req_valid held high
      wait_idle();
      base = rsp_count;
      bif.req_write = 1'b1;
      bif.req_addr  = 4'h1;
      bif.req_wdata = 8'h11;
      bif.req_valid = 1'b1;
      tick();
      bif.req_addr  = 4'h2;
      bif.req_wdata = 8'h22;
      chk("b2b_busy", bif.busy, 1);
      chk("b2b_not_ready", bif.req_ready, 0);
      n = 0;
      while (bif.req_ready !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      chk("b2b_ready_timeout", bif.req_ready, 1);
      tick();
      bif.req_valid = 1'b0;
      wait_rsp(base + 2);
      repeat (20) tick();
      chk("b2b_two_rsp", rsp_count, base + 2);

      // async reset during ACTIVE of a write
      wait_idle();
      issue(1'b1, 4'h7, 8'h3C);
      n = 0;
      while (!(bif.cs === 1'b0 && bif.clk_ext1 === 1'b1) && n < 60) begin
         tick();
         n++;
      end
      chk("active_reached", {bif.cs, bif.clk_ext1}, 2'b01);
      base = rsp_count;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_cs", bif.cs, 1);
      chk("arst_data_oe", bif.data_oe, 0);
      chk("arst_wren", bif.wren, 1);
      chk("arst_busy", bif.busy, 0);
      tick();
      rst = 1'b0;
      repeat (40) tick();
      chk("arst_no_rsp", rsp_count, base);
      chk("arst_req_ready", bif.req_ready, 1);
      chk("arst_cs_idle", bif.cs, 1);

      // latency across all phi2 phases
      for (int p = 0; p < 2*DIV; p++) begin
         wait_idle();
         repeat (p) tick();
         bif.data_in = 8'(8'h40 + p);
         base = rsp_count;
         issue(p[0], 4'(p), 8'(p * 17));
         wait_rsp(base + 1);
      end

      repeat (4) tick();
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
